// File: rtl/uart_rx_frame_writer_pkg.sv
// Shared constants for the host-link UART upload path: bit timing, RAM port widths and
// the controller state encoding (kept in step with the transmit-side controller).
package uart_rx_frame_writer_pkg;

  localparam int CLKS_PER_BIT = 434;
  localparam int ADDR_W       = 25;
  localparam int DATA_W       = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start
// detection and stop-bit check.
module uart_rx
  import uart_rx_frame_writer_pkg::*;
#(
  parameter int CLKS = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CNT_W = $clog2(CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS - 1);

  logic             rx_s1, rx_s2, rx_q;
  logic [2:0]       st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign byte_data = shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_q       <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_q       <= rx_s2;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      cnt        <= cnt + CNT_W'(1);
      case (st)
        RX_IDLE: if (rx_q && !rx_s2) begin
          st  <= RX_START;
          cnt <= '0;
        end
        // a start bit that is high again at its midpoint was only a glitch
        RX_START: if (cnt == HALF_M1) begin
          cnt     <= '0;
          bit_idx <= '0;
          st      <= rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == FULL_M1) begin
          cnt     <= '0;
          shreg   <= {rx_s2, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) st <= RX_STOP;
        end
        RX_STOP: if (cnt == FULL_M1) begin
          cnt <= '0;
          if (rx_s2) begin
            byte_valid <= 1'b1;
            st         <= RX_IDLE;
          end else begin
            stop_err <= 1'b1;
            st       <= RX_WAIT;
          end
        end
        RX_WAIT: if (rx_s2) st <= RX_IDLE;
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_frame_writer.sv
// Host-link upload: packs received UART bytes into 128-bit words (first byte in [7:0]) and
// writes one frame's worth of words to SDRAM through the shared req/busy port.
module uart_rx_frame_writer
  import uart_rx_frame_writer_pkg::*;
#(
  parameter int                CLKS_PER_BIT    = uart_rx_frame_writer_pkg::CLKS_PER_BIT,
  parameter logic [17:0]       WORDS_PER_FRAME = 18'h1C200,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 25'h0,
  parameter int                ADDR_STEP       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  logic              start,
  input  logic              ram_busy,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy_led
);

  logic       byte_valid, stop_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (RX),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  logic [1:0]        state;
  logic              start_q;
  logic [3:0]        byte_idx;
  logic [DATA_W-9:0] asm_reg;
  logic              pend, adv;
  logic [17:0]       word_cnt;

  // wr_req is combinational so a busy RAM port is honoured in the very cycle it is seen
  assign wr_req   = (state == ST_ARMED) && pend && !ram_busy;
  assign done     = (state == ST_DONE);
  assign busy_led = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      byte_idx   <= '0;
      asm_reg    <= '0;
      wr_data    <= '0;
      pend       <= 1'b0;
      adv        <= 1'b0;
      word_cnt   <= '0;
      wr_address <= BASE_ADDR;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      start_q <= start;
      adv     <= wr_req;
      if (stop_err) frame_err <= 1'b1;
      case (state)
        ST_IDLE: if (start && !start_q) begin
          state      <= ST_ARMED;
          word_cnt   <= '0;
          byte_idx   <= '0;
          frame_err  <= 1'b0;
          overrun    <= 1'b0;
          pend       <= 1'b0;
          wr_address <= BASE_ADDR;
        end
        ST_ARMED: begin
          if (wr_req) pend <= 1'b0;
          if (byte_valid) begin
            byte_idx <= byte_idx + 4'd1;
            for (int i = 0; i < 15; i++)
              if (byte_idx == 4'(i)) asm_reg[8*i +: 8] <= byte_data;
            // a full word while the previous one is still unwritten is dropped
            if (byte_idx == 4'hF) begin
              if (pend) begin
                overrun <= 1'b1;
              end else begin
                wr_data <= {byte_data, asm_reg};
                pend    <= 1'b1;
              end
            end
          end
          if (adv) begin
            wr_address <= wr_address + ADDR_W'(ADDR_STEP);
            word_cnt   <= word_cnt + 18'd1;
          end
          if (word_cnt == WORDS_PER_FRAME) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_writer.sv
// Directed bench for the UART upload path: packing, busy back-pressure, overrun, framing
// errors, glitch rejection and reset mid-upload.
module tb_uart_rx_frame_writer;

  logic         clk = 1'b0;
  logic         rst_n, RX, start, ram_busy;
  logic         wr_req, done, frame_err, overrun, busy_led;
  logic [24:0]  wr_address;
  logic [127:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_frame_writer #(
    .CLKS_PER_BIT    (8),
    .WORDS_PER_FRAME (18'd2),
    .BASE_ADDR       (25'h70800)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .start      (start),
    .ram_busy   (ram_busy),
    .wr_req     (wr_req),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .done       (done),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy_led   (busy_led)
  );

  always #5 clk = ~clk;

  // write/done/byte monitor, sampled mid-cycle
  int           cyc = 0, last_bv = 0, wr_cnt = 0, done_cnt = 0, bv_cnt = 0;
  logic [24:0]  wa  [0:15];
  logic [127:0] wd  [0:15];
  int           gap [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.u_rx.byte_valid) begin
      last_bv = cyc;
      bv_cnt++;
    end
    if (wr_req && wr_cnt < 16) begin
      wa[wr_cnt]  = wr_address;
      wd[wr_cnt]  = wr_data;
      gap[wr_cnt] = cyc - last_bv;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(8);
    end
    RX = stop;
    tick(8);
    RX = 1'b1;
    tick(4);
  endtask

  task automatic send_run(input logic [7:0] first, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      send_byte(b, 1'b1);
      b = b + 8'd1;
    end
  endtask

  task automatic arm();
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  int w0, b0;

  initial begin
    rst_n = 1'b0; RX = 1'b1; start = 1'b0; ram_busy = 1'b0;
    tick(3);
    check("rst_wr_req",  wr_req,     1'b0);
    check("rst_addr",    wr_address, 25'h70800);
    check("rst_data",    wr_data,    128'h0);
    check("rst_done",    done,       1'b0);
    check("rst_ferr",    frame_err,  1'b0);
    check("rst_ovr",     overrun,    1'b0);
    check("rst_led",     busy_led,   1'b1);
    rst_n = 1'b1;
    tick(2);

    // 1: full two-word upload
    arm();
    check("t1_led_armed", busy_led, 1'b0);
    send_run(8'h00, 32);
    tick(10);
    check("t1_wr_cnt", wr_cnt, 2);
    check("t1_addr0",  wa[0],  25'h70800);
    check("t1_data0",  wd[0],  128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_addr1",  wa[1],  25'h70804);
    check("t1_data1",  wd[1],  128'h1F1E1D1C1B1A19181716151413121110);
    check("t1_latency", gap[0], 1);
    check("t1_done",   done_cnt, 1);
    check("t1_led_idle", busy_led, 1'b1);

    // 2: ram_busy holds the first word back
    do_reset();
    arm();
    ram_busy = 1'b1;
    w0 = wr_cnt;
    send_run(8'h20, 16);
    tick(10);
    check("t2_no_req_busy", wr_cnt, w0);
    check("t2_staged",      wr_data, 128'h2F2E2D2C2B2A29282726252423222120);
    ram_busy = 1'b0;
    tick(1);
    check("t2_req_fired", wr_cnt, w0 + 1);
    check("t2_addr",      wa[w0], 25'h70800);
    check("t2_data",      wd[w0], 128'h2F2E2D2C2B2A29282726252423222120);

    // 3: overrun while busy across two words
    do_reset();
    arm();
    ram_busy = 1'b1;
    w0 = wr_cnt;
    send_run(8'h40, 32);
    tick(5);
    check("t3_overrun",  overrun, 1'b1);
    check("t3_no_req",   wr_cnt, w0);
    ram_busy = 1'b0;
    tick(5);
    check("t3_one_write", wr_cnt, w0 + 1);
    check("t3_addr",      wa[w0], 25'h70800);
    check("t3_data",      wd[w0], 128'h4F4E4D4C4B4A49484746454443424140);
    check("t3_word_cnt",  dut.word_cnt, 18'd1);
    tick(50);
    check("t3_no_more",   wr_cnt, w0 + 1);
    check("t3_ovr_sticky", overrun, 1'b1);

    // 4: framing error drops the byte
    do_reset();
    arm();
    w0 = wr_cnt;
    send_byte(8'h55, 1'b0);
    tick(4);
    check("t4_frame_err", frame_err, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_run(8'h01, 15);
    tick(5);
    check("t4_write",     wr_cnt, w0 + 1);
    check("t4_data",      wd[w0], 128'h0F0E0D0C0B0A090807060504030201A5);
    check("t4_ferr_sticky", frame_err, 1'b1);

    // 5: RX glitch in idle, then complete the upload
    b0 = bv_cnt;
    RX = 1'b0;
    tick(2);
    RX = 1'b1;
    tick(12);
    check("t5_glitch_no_byte", bv_cnt, b0);
    w0 = wr_cnt;
    b0 = done_cnt;
    send_run(8'h80, 16);
    tick(10);
    check("t5_write", wr_cnt, w0 + 1);
    check("t5_addr",  wa[w0], 25'h70804);
    check("t5_data",  wd[w0], 128'h8F8E8D8C8B8A89888786858483828180);
    check("t5_done",  done_cnt, b0 + 1);
    check("t5_led",   busy_led, 1'b1);

    // 6: reset mid-upload
    arm();
    check("t6_ferr_cleared", frame_err, 1'b0);
    w0 = wr_cnt;
    send_run(8'h10, 20);
    check("t6_first_word", wr_cnt, w0 + 1);
    rst_n = 1'b0;
    tick(2);
    check("t6_rst_req",  wr_req,     1'b0);
    check("t6_rst_addr", wr_address, 25'h70800);
    check("t6_rst_data", wr_data,    128'h0);
    check("t6_rst_done", done,       1'b0);
    check("t6_rst_led",  busy_led,   1'b1);
    rst_n = 1'b1;
    tick(60);
    check("t6_no_req_after_rst", wr_cnt, w0 + 1);
    w0 = wr_cnt;
    arm();
    send_run(8'hC0, 16);
    tick(5);
    check("t6_restart_write", wr_cnt, w0 + 1);
    check("t6_restart_addr",  wa[w0], 25'h70800);
    check("t6_restart_data",  wd[w0], 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
